// File: rtl/ic74163_counter.sv
// 74x163-style synchronous presettable modulo-N counter with ripple carry out.
// Define IC74163_EDGE_EN to count once per rising edge of enp instead of on its level.
module ic74163_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             load_n,
   input  logic             enp,
   input  logic             ent,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             rco
);

   localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             at_term;
   logic             cnt_en;

   assign at_term = (cnt_q == TERM);

`ifdef IC74163_EDGE_EN
   logic enp_q;
   logic enp_d;

   // Previous enp is tracked every cycle, even while loading.
   always_comb begin
      enp_d = enp;
      if (!clr_n) begin
         enp_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      enp_q <= enp_d;
   end

   assign cnt_en = enp & ~enp_q & ent;
`else
   assign cnt_en = enp & ent;
`endif

   // A loaded value above TERM keeps counting and wraps on WIDTH-bit overflow.
   always_comb begin
      cnt_d = cnt_q;
      if (!clr_n) begin
         cnt_d = '0;
      end else if (!load_n) begin
         cnt_d = d;
      end else if (cnt_en) begin
         if (at_term) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign q   = cnt_q;
   assign rco = ent & at_term;

endmodule

// File: tb/tb_ic74163_counter.sv
// Directed bench for ic74163_counter: reset, free count, decade, gating, cascade, enp edge mode.
module tb_ic74163_counter;

   logic       clk = 1'b0;
   logic       clr_n, load_n, enp, ent;
   logic [3:0] d;
   logic [3:0] q_main, q_dec, q_c0, q_c1;
   logic       rco_main, rco_dec, rco_c0, rco_c1;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   ic74163_counter #(.WIDTH(4), .MODULUS(16)) u_main (
      .clk(clk), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent),
      .d(d), .q(q_main), .rco(rco_main));

   ic74163_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
      .clk(clk), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent),
      .d(d), .q(q_dec), .rco(rco_dec));

   ic74163_counter #(.WIDTH(4), .MODULUS(16)) u_c0 (
      .clk(clk), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent),
      .d(d), .q(q_c0), .rco(rco_c0));

   ic74163_counter #(.WIDTH(4), .MODULUS(16)) u_c1 (
      .clk(clk), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(rco_c0),
      .d(d), .q(q_c1), .rco(rco_c1));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One qualifying count; the edge build needs a fresh 0->1 on enp each time.
   task automatic cnt();
`ifdef IC74163_EDGE_EN
      enp = 1'b0;
      tick();
      enp = 1'b1;
      tick();
`else
      enp = 1'b1;
      tick();
`endif
   endtask

   initial begin
      // Reset with load and enables also active: clear wins.
      clr_n = 1'b0; load_n = 1'b0; d = 4'hA; enp = 1'b1; ent = 1'b1;
      tick();
      chk("rst_q", 16'(q_main), 16'h0);
      chk("rst_rco", 16'(rco_main), 16'h0);
      chk("rst_dec_q", 16'(q_dec), 16'h0);
      tick();
      chk("rst2_q", 16'(q_main), 16'h0);

      // Free count 0..15 then wrap.
      clr_n = 1'b1; load_n = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         cnt();
         chk($sformatf("free_q%0d", i), 16'(q_main), 16'(i % 16));
         chk($sformatf("free_rco%0d", i), 16'(rco_main), 16'((i % 16) == 15));
      end

      // Decade: load 7 with enables high (load wins), then 8,9,0,1.
      load_n = 1'b0; d = 4'd7; enp = 1'b1;
      tick();
      chk("dec_load7", 16'(q_dec), 16'd7);
      chk("main_load7", 16'(q_main), 16'd7);
      load_n = 1'b1;
      cnt(); chk("dec_8", 16'(q_dec), 16'd8); chk("dec_rco8", 16'(rco_dec), 16'd0);
      cnt(); chk("dec_9", 16'(q_dec), 16'd9); chk("dec_rco9", 16'(rco_dec), 16'd1);
      cnt(); chk("dec_0", 16'(q_dec), 16'd0); chk("dec_rco0", 16'(rco_dec), 16'd0);
      cnt(); chk("dec_1", 16'(q_dec), 16'd1);

      // Decade loaded above terminal count runs up to the WIDTH-bit wrap.
      load_n = 1'b0; d = 4'd12;
      tick();
      chk("dec_load12", 16'(q_dec), 16'd12);
      load_n = 1'b1;
      cnt(); chk("dec_13", 16'(q_dec), 16'd13);
      cnt(); chk("dec_14", 16'(q_dec), 16'd14);
      cnt(); chk("dec_15", 16'(q_dec), 16'd15);
      chk("dec_rco15", 16'(rco_dec), 16'd0);
      chk("main_rco15", 16'(rco_main), 16'd1);
      cnt(); chk("dec_wrap", 16'(q_dec), 16'd0);

      // Enable gating at terminal count.
      load_n = 1'b0; d = 4'd15;
      tick();
      load_n = 1'b1; enp = 1'b0; ent = 1'b1;
      tick();
      chk("gate_hold_q", 16'(q_main), 16'd15);
      chk("gate_rco_hi", 16'(rco_main), 16'd1);
      ent = 1'b0;
      #1;
      chk("gate_rco_comb", 16'(rco_main), 16'd0);
      enp = 1'b1;
      tick();
      chk("gate_ent0_q", 16'(q_main), 16'd15);
      chk("gate_ent0_rco", 16'(rco_main), 16'd0);

      // Reset mid-count, then counting resumes from 0.
      ent = 1'b1; clr_n = 1'b0;
      tick();
      chk("midrst_q", 16'(q_main), 16'd0);
      clr_n = 1'b1;
      cnt();
      chk("resume_q", 16'(q_main), 16'd1);

      // Two-stage cascade from 0.
      clr_n = 1'b0; enp = 1'b0;
      tick();
      clr_n = 1'b1; ent = 1'b1;
      for (int i = 0; i < 16; i++) cnt();
      chk("casc_16", 16'({q_c1, q_c0}), 16'h10);
      for (int i = 0; i < 4; i++) cnt();
      chk("casc_20", 16'({q_c1, q_c0}), 16'h14);

      // enp high 5, low 2, high 3 with ent=1.
      clr_n = 1'b0; enp = 1'b0;
      tick();
      clr_n = 1'b1; ent = 1'b1;
      enp = 1'b1; repeat (5) tick();
      enp = 1'b0; repeat (2) tick();
      enp = 1'b1; repeat (3) tick();
`ifdef IC74163_EDGE_EN
      chk("edge_q", 16'(q_main), 16'd2);
`else
      chk("level_q", 16'(q_main), 16'd8);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
